// File: rtl/vector_scalar_pack_unit.sv
// vector_scalar_pack_unit
// Collects the lane-0 scalar of successive zero-padded reduced vectors into a
// dense N-lane vector and emits it when full, on end-of-frame, or when the
// chain tag changes. With pack_en low the unit is a one-cycle passthrough.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   pack_en      1 = pack mode, 0 = passthrough (static config)
//   valid_in     vector_in / chainId_in valid this cycle
//   eof_in       end of frame, with or without valid_in
//   chainId_in   chain tag of the incoming scalar
//   vector_in    N lanes of DATA_WIDTH; only lane 0 used in pack mode
//   valid_out    vector_out valid (single-cycle pulse)
//   eof_out      last vector of frame / bare frame marker (single-cycle pulse)
//   chainId_out  chain tag of the emitted vector
//   count_out    populated lanes in vector_out
//   vector_out   packed vector, lane i = i-th scalar, unused lanes 0
module vector_scalar_pack_unit #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pack_en,
  input  logic                               valid_in,
  input  logic                               eof_in,
  input  logic                               chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
  output logic                               valid_out,
  output logic                               eof_out,
  output logic                               chainId_out,
  output logic [$clog2(N+1)-1:0]             count_out,
  output logic [N-1:0][DATA_WIDTH-1:0]       vector_out
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(N);

  logic [N-1:0][DATA_WIDTH-1:0] lane_buf_q, lane_buf_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         cur_chain_q, cur_chain_d;
  // Set when a chain switch arrived together with eof: the lone new scalar
  // sitting in lane 0 must be flushed with eof on the following cycle.
  logic                         pend_eof_q, pend_eof_d;

  logic                         valid_d, eof_d, chain_d;
  logic [CW-1:0]                count_d;
  logic [N-1:0][DATA_WIDTH-1:0] vec_d;

  always_comb begin
    lane_buf_d  = lane_buf_q;
    idx_d       = idx_q;
    cur_chain_d = cur_chain_q;
    pend_eof_d  = pend_eof_q;
    valid_d     = 1'b0;
    eof_d       = 1'b0;
    chain_d     = 1'b0;
    count_d     = '0;
    vec_d       = '0;

    if (!pack_en) begin
      // Passthrough; any partially filled buffer is discarded silently.
      valid_d    = valid_in;
      eof_d      = eof_in;
      chain_d    = chainId_in;
      count_d    = COUNT_FULL;
      vec_d      = vector_in;
      lane_buf_d = '0;
      idx_d      = '0;
      pend_eof_d = 1'b0;
    end else if (pend_eof_q) begin
      valid_d    = 1'b1;
      eof_d      = 1'b1;
      chain_d    = cur_chain_q;
      count_d    = CW'(1);
      vec_d      = lane_buf_q;
      lane_buf_d = '0;
      idx_d      = '0;
      pend_eof_d = 1'b0;
      // A beat arriving in the flush cycle starts a fresh buffer.
      if (valid_in) begin
        lane_buf_d[0] = vector_in[0];
        idx_d         = IW'(1);
        cur_chain_d   = chainId_in;
        pend_eof_d    = eof_in;
      end
    end else if (valid_in && (idx_q != '0) && (chainId_in != cur_chain_q)) begin
      valid_d       = 1'b1;
      chain_d       = cur_chain_q;
      count_d       = CW'(idx_q);
      vec_d         = lane_buf_q;
      lane_buf_d    = '0;
      lane_buf_d[0] = vector_in[0];
      idx_d         = IW'(1);
      cur_chain_d   = chainId_in;
      pend_eof_d    = eof_in;
    end else if (valid_in && ((idx_q == IDX_LAST) || eof_in)) begin
      valid_d       = 1'b1;
      eof_d         = eof_in;
      chain_d       = chainId_in;
      count_d       = CW'(idx_q) + CW'(1);
      vec_d         = lane_buf_q;
      vec_d[idx_q]  = vector_in[0];
      lane_buf_d    = '0;
      idx_d         = '0;
      cur_chain_d   = chainId_in;
    end else if (valid_in) begin
      lane_buf_d[idx_q] = vector_in[0];
      idx_d             = idx_q + IW'(1);
      cur_chain_d       = chainId_in;
    end else if (eof_in) begin
      eof_d = 1'b1;
      if (idx_q != '0) begin
        valid_d    = 1'b1;
        chain_d    = cur_chain_q;
        count_d    = CW'(idx_q);
        vec_d      = lane_buf_q;
        lane_buf_d = '0;
        idx_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_buf_q  <= '0;
      idx_q       <= '0;
      cur_chain_q <= 1'b0;
      pend_eof_q  <= 1'b0;
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= 1'b0;
      count_out   <= '0;
      vector_out  <= '0;
    end else begin
      lane_buf_q  <= lane_buf_d;
      idx_q       <= idx_d;
      cur_chain_q <= cur_chain_d;
      pend_eof_q  <= pend_eof_d;
      valid_out   <= valid_d;
      eof_out     <= eof_d;
      chainId_out <= chain_d;
      count_out   <= count_d;
      vector_out  <= vec_d;
    end
  end

endmodule
